// File: rtl/lcd_spi_arbiter.sv
// Two-requester arbiter that frames byte bursts to an SPI LCD serializer under lcd_cs.
// Define LCD_ARB_RR_EN for round-robin arbitration; fixed priority (req0 first) otherwise.
module lcd_spi_arbiter #(
   parameter int unsigned CS_GAP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic       req0_last,
   input  logic [7:0] req0_byte,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic       req1_last,
   input  logic [7:0] req1_byte,
   output logic       req1_ready,
   output logic       ser_valid,
   output logic [7:0] ser_byte,
   output logic       ser_rs,
   input  logic       ser_ready,
   input  logic       ser_idle,
   output logic       lcd_cs,
   output logic [1:0] grant,
   output logic       busy
);

   localparam int unsigned GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t          state;
   logic [GW-1:0]   gap_cnt;
   logic            pick1;
   logic            cur_last;

`ifdef LCD_ARB_RR_EN
   logic            rr_ptr;

   // rr_ptr holds the last granted index; a tie goes to the other requester
   assign pick1 = req1_valid && (!req0_valid || !rr_ptr);
`else
   assign pick1 = req1_valid && !req0_valid;
`endif

   always_comb begin
      ser_valid  = 1'b0;
      ser_byte   = '0;
      ser_rs     = 1'b0;
      cur_last   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state == S_XFER) begin
         if (grant[1]) begin
            ser_valid  = req1_valid;
            ser_byte   = req1_byte;
            ser_rs     = req1_rs;
            cur_last   = req1_last;
            req1_ready = ser_ready;
         end else begin
            ser_valid  = req0_valid;
            ser_byte   = req0_byte;
            ser_rs     = req0_rs;
            cur_last   = req0_last;
            req0_ready = ser_ready;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         lcd_cs  <= 1'b1;
         grant   <= '0;
         busy    <= 1'b0;
         gap_cnt <= '0;
`ifdef LCD_ARB_RR_EN
         rr_ptr  <= 1'b1;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_valid || req1_valid) begin
                  state  <= S_SETUP;
                  lcd_cs <= 1'b0;
                  busy   <= 1'b1;
                  grant  <= pick1 ? 2'b10 : 2'b01;
`ifdef LCD_ARB_RR_EN
                  rr_ptr <= pick1;
`endif
               end
            end
            S_SETUP: state <= S_XFER;
            S_XFER: begin
               if (ser_valid && ser_ready && cur_last)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (ser_idle) begin
                  lcd_cs <= 1'b1;
                  grant  <= '0;
                  if (CS_GAP > 0) begin
                     state   <= S_GAP;
                     gap_cnt <= GW'(CS_GAP - 1);
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               lcd_cs <= 1'b1;
               grant  <= '0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/lcd_spi_arbiter.md
LCD_SPI_ARBITER -- requirements
Module: lcd_spi_arbiter

Interface
REQ-001 Parameter: CS_GAP, default 2, minimum cycles lcd_cs held high between bursts (range 0..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 req0_valid/req0_rs/req0_last  input  1 each  requester 0 (init sequencer) byte valid, D/C bit (0=cmd, 1=data), last byte of burst.
REQ-005 req0_byte  input  8  requester 0 byte.
REQ-006 req0_ready  output  1  requester 0 byte accepted.
REQ-007 req1_valid/req1_rs/req1_last  input  1 each; req1_byte  input  8; req1_ready  output  1; requester 1 (pixel writer), same meaning as requester 0.
REQ-008 ser_valid  output  1; ser_byte  output  8; ser_rs  output  1: byte offered to the SPI serializer.
REQ-009 ser_ready  input  1  serializer accepts the byte this cycle; ser_idle  input  1  serializer shift register empty.
REQ-010 lcd_cs  output  1  panel chip select, active low.
REQ-011 grant  output  2  one-hot owner (bit0=req0, bit1=req1), 0 when unowned; busy  output  1  state != IDLE.

Function
REQ-012 FSM states: IDLE, SETUP, XFER, DRAIN, GAP.
REQ-013 IDLE: lcd_cs=1, grant=0; if any reqN_valid=1, latch the winner into grant and go to SETUP next cycle.
REQ-014 SETUP: lcd_cs=0, lasts exactly 1 cycle, no transfer; then XFER.
REQ-015 XFER: lcd_cs=0; ser_valid/ser_byte/ser_rs combinationally equal the granted requester's valid/byte/rs; granted reqN_ready = ser_ready.
REQ-016 Transfer occurs on ser_valid&&ser_ready; a transfer with granted last=1 moves to DRAIN.
REQ-017 Non-granted requester ready SHALL be 0 in every state; ready of both SHALL be 0 outside XFER.
REQ-018 Granted requester deasserting valid mid-burst: ser_valid=0, lcd_cs stays 0, grant held, no timeout.
REQ-019 DRAIN: lcd_cs=0, ser_valid=0; on ser_idle=1 go to GAP (CS_GAP>0) or IDLE (CS_GAP=0).
REQ-020 GAP: lcd_cs=1, grant=0; counter loaded with CS_GAP-1 on entry, decrements each cycle, exits to IDLE when 0 (lcd_cs high exactly CS_GAP cycles before IDLE).
REQ-021 Gap counter width $clog2(CS_GAP+1), minimum 1 bit; no wrap permitted.
REQ-022 Single-byte burst (last=1 on first byte) SHALL follow SETUP->XFER->DRAIN normally.
REQ-023 Requests arriving during SETUP/XFER/DRAIN/GAP SHALL wait; no preemption; arbitration only in IDLE.
REQ-024 ser_ready=1 with ser_valid=0 SHALL not count as a transfer.
REQ-025 Minimum burst latency: request in IDLE at cycle 0 -> first byte offered on ser_valid at cycle 2.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) force IDLE, lcd_cs=1, ser_valid=0, req0_ready=req1_ready=0, grant=0, busy=0, gap counter=0, RR pointer=1.
REQ-027 Reset mid-burst SHALL abandon the burst; after release, arbitration restarts from IDLE.

Configuration
REQ-028 Macro LCD_ARB_RR_EN undefined: fixed priority, req0 wins when both valid in IDLE.
REQ-029 LCD_ARB_RR_EN defined: round-robin; 1-bit pointer holds last-granted index, simultaneous requests go to the other requester; pointer updates on grant; reset value 1 so req0 wins first tie; single requester always wins.

Verification
REQ-030 req0 burst 0x2A(rs=0),0x00,0x00,0x00,0x87(last), ser_ready=1 -> lcd_cs low from cycle 1, 5 bytes out with rs 0,1,1,1,1, then DRAIN, lcd_cs high 2 cycles, IDLE.
REQ-031 req0 and req1 valid same cycle, macro undefined, twice -> grant=01 both times; macro defined -> 01 then 10.
REQ-032 req1 burst of 3 with ser_ready toggling 1,0,1,0,1 -> exactly 3 transfers, req0_ready stays 0 with req0_valid=1, req0 granted only after GAP.
REQ-033 rst driven low during XFER byte 2 -> same-cycle lcd_cs=1, ser_valid=0, grant=0; new burst after release starts at SETUP.
REQ-034 CS_GAP=0, back-to-back single-byte bursts 0x29 -> lcd_cs high exactly 1 cycle (IDLE) between bursts.
REQ-035 ser_idle held 0 for 10 cycles after last byte -> state DRAIN, lcd_cs=0 for all 10 cycles.
